// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types for the data_ram arbiter
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_t;

  // A one-bit counter is still needed when LOCK_MAX is 1, so the width is never 0.
  function automatic int lock_cnt_width(input int lock_max);
    return (lock_max > 1) ? $clog2(lock_max) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - M0/M1 request ports and the data_ram port of the arbiter
interface ram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 4
);
  logic          m0_req;
  logic          m0_we;
  logic [SW-1:0] m0_sel;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;
  logic          m0_stall;

  logic          m1_req;
  logic          m1_we;
  logic [SW-1:0] m1_sel;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;
  logic          m1_lock;

  logic          ram_ce;
  logic          ram_we;
  logic [SW-1:0] ram_sel;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  m0_req, m0_we, m0_sel, m0_addr, m0_wdata,
    output m0_rdata, m0_ack, m0_stall,
    input  m1_req, m1_we, m1_sel, m1_addr, m1_wdata, m1_lock,
    output m1_rdata, m1_ack,
    output ram_ce, ram_we, ram_sel, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_req, m0_we, m0_sel, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack, m0_stall,
    output m1_req, m1_we, m1_sel, m1_addr, m1_wdata, m1_lock,
    input  m1_rdata, m1_ack,
    input  ram_ce, ram_we, ram_sel, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - grant selection for an idle arbiter
// ARB_ROUND_ROBIN_EN: simultaneous requests go to the master that was not served last.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic    req0,
  input  logic    req1,
  input  master_t last,
  output master_t gnt,
  output logic    valid
);

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    valid = req0 | req1;
    gnt   = M0;
    if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt = (last == M0) ? M1 : M0;
`else
      gnt = M0;
`endif
    end else if (req1) begin
      gnt = M1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares the data_ram port between cpu (M0) and DMA (M1)
// ARB_ROUND_ROBIN_EN (in ram_arb_pick) switches simultaneous requests from M0 priority to round robin.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int SW       = 4,
  parameter int LOCK_MAX = 16
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  localparam int LCW = lock_cnt_width(LOCK_MAX);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_MAX - 1);

  arb_state_t    state;
  master_t       last;
  logic [LCW-1:0] lock_cnt;

  master_t       pick_gnt;
  logic          pick_valid;
  logic          acc0;
  logic          acc1;
  logic          mux_we;
  logic [SW-1:0] mux_sel;
  logic [AW-1:0] mux_addr;
  logic [DW-1:0] mux_wdata;

  ram_arb_pick u_pick (
    .req0  (bus.m0_req),
    .req1  (bus.m1_req),
    .last  (last),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // A grant only turns into a ram access while its master still requests.
  always_comb begin
    acc0      = (state == GNT0) && bus.m0_req;
    acc1      = (state == GNT1) && bus.m1_req;
    mux_we    = 1'b0;
    mux_sel   = '0;
    mux_addr  = '0;
    mux_wdata = '0;
    if (acc0) begin
      mux_we    = bus.m0_we;
      mux_sel   = bus.m0_sel;
      mux_addr  = bus.m0_addr;
      mux_wdata = bus.m0_wdata;
    end else if (acc1) begin
      mux_we    = bus.m1_we;
      mux_sel   = bus.m1_sel;
      mux_addr  = bus.m1_addr;
      mux_wdata = bus.m1_wdata;
    end
  end

  assign bus.ram_ce    = acc0 | acc1;
  assign bus.ram_we    = mux_we;
  assign bus.ram_sel   = mux_sel;
  assign bus.ram_addr  = mux_addr;
  assign bus.ram_wdata = mux_wdata;
  assign bus.m0_ack    = acc0;
  assign bus.m1_ack    = acc1;
  assign bus.m0_rdata  = acc0 ? bus.ram_rdata : '0;
  assign bus.m1_rdata  = acc1 ? bus.ram_rdata : '0;
  assign bus.m0_stall  = bus.m0_req & ~acc0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= M1;
      lock_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          lock_cnt <= '0;
          if (pick_valid) begin
            state <= (pick_gnt == M0) ? GNT0 : GNT1;
          end
        end
        GNT0: begin
          if (acc0) begin
            last <= M0;
          end
          state <= IDLE;
        end
        GNT1: begin
          if (acc1) begin
            last <= M1;
          end
          // lock_cnt counts beats already taken, so LOCK_LAST marks the final allowed one.
          if (acc1 && bus.m1_lock && (lock_cnt < LOCK_LAST)) begin
            lock_cnt <= lock_cnt + 1'b1;
          end else begin
            state    <= IDLE;
            lock_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a transaction-level owner model
module tb_ram_arbiter;

  localparam int LOCK_MAX = 16;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.AW(32), .DW(32), .SW(4)) bus ();

  ram_arbiter #(.AW(32), .DW(32), .SW(4), .LOCK_MAX(LOCK_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:63];
  assign bus.ram_rdata = mem[bus.ram_addr[7:2]];

  always @(posedge clk) begin
    if (bus.ram_ce && bus.ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_sel[b]) mem[bus.ram_addr[7:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int acklog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: who currently owns the ram (-1 none), beats taken in the current M1 burst, last served.
  int owner = -1;
  int run   = 0;
  int last  = 1;

  always @(posedge clk) begin
    if (rst) begin
      owner = -1;
      run   = 0;
      last  = 1;
    end else if (owner == -1) begin
      if (bus.m0_req && bus.m1_req) owner = RR ? ((last == 0) ? 1 : 0) : 0;
      else if (bus.m0_req)          owner = 0;
      else if (bus.m1_req)          owner = 1;
    end else if (owner == 0) begin
      if (bus.m0_req) last = 0;
      owner = -1;
    end else begin
      if (bus.m1_req) begin
        last = 1;
        run++;
        if (!(bus.m1_lock && run < LOCK_MAX)) begin
          owner = -1;
          run   = 0;
        end
      end else begin
        owner = -1;
        run   = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic        e0, e1;
    logic        ewe;
    logic [3:0]  esel;
    logic [31:0] eaddr, ewdata;
    e0 = (owner == 0) && bus.m0_req;
    e1 = (owner == 1) && bus.m1_req;
    ewe = 1'b0; esel = '0; eaddr = '0; ewdata = '0;
    if (e0) begin
      ewe = bus.m0_we; esel = bus.m0_sel; eaddr = bus.m0_addr; ewdata = bus.m0_wdata;
    end else if (e1) begin
      ewe = bus.m1_we; esel = bus.m1_sel; eaddr = bus.m1_addr; ewdata = bus.m1_wdata;
    end
    check("ram_ce", bus.ram_ce, e0 | e1);
    check("ram_we", bus.ram_we, ewe);
    check("ram_sel", bus.ram_sel, esel);
    check("ram_addr", bus.ram_addr, eaddr);
    check("ram_wdata", bus.ram_wdata, ewdata);
    check("m0_ack", bus.m0_ack, e0);
    check("m1_ack", bus.m1_ack, e1);
    check("m0_rdata", bus.m0_rdata, e0 ? mem[eaddr[7:2]] : 32'h0);
    check("m1_rdata", bus.m1_rdata, e1 ? mem[eaddr[7:2]] : 32'h0);
    check("m0_stall", bus.m0_stall, bus.m0_req & ~e0);
    acklog.push_back(bus.m0_ack ? 1 : (bus.m1_ack ? 2 : 0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    int m1_beats;
    int exp_seq [8];

    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    rst = 1'b1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_sel = 4'hf; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_sel = 4'hf; bus.m1_addr = 0; bus.m1_wdata = 0;
    bus.m1_lock = 0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_ce", bus.ram_ce, 1'b0);
    check("reset_acks", {bus.m0_ack, bus.m1_ack}, 2'b00);
    check("reset_rdata", bus.m0_rdata, 32'h0);

    // M0 read of 0x10
    step();
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h10;
    @(negedge clk);
    check("rd_stall_t", bus.m0_stall, 1'b1);
    check("rd_ack_t", bus.m0_ack, 1'b0);
    step();
    @(negedge clk);
    check("rd_ack_t1", bus.m0_ack, 1'b1);
    check("rd_ce_t1", bus.ram_ce, 1'b1);
    check("rd_we_t1", bus.ram_we, 1'b0);
    check("rd_data_t1", bus.m0_rdata, 32'h1000_0004);
    check("rd_stall_t1", bus.m0_stall, 1'b0);
    step();
    bus.m0_req = 0;

    // M1 partial write, then M0 readback
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_sel = 4'b0011; bus.m1_addr = 32'h20;
    bus.m1_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wr_ack_t", bus.m1_ack, 1'b0);
    step();
    @(negedge clk);
    check("wr_ack_t1", bus.m1_ack, 1'b1);
    check("wr_we_t1", bus.ram_we, 1'b1);
    check("wr_sel_t1", bus.ram_sel, 4'b0011);
    step();
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_sel = 4'hf;
    bus.m0_req = 1; bus.m0_addr = 32'h20;
    step();
    @(negedge clk);
    check("wr_readback", bus.m0_rdata, 32'h1000_BEEF);
    step();
    bus.m0_req = 0;

    // Both masters requesting every cycle; last served is M0 here
    bus.m0_req = 1; bus.m0_addr = 32'h0;
    bus.m1_req = 1; bus.m1_addr = 32'h4;
    s = acklog.size();
    if (RR) exp_seq = '{0, 2, 0, 1, 0, 2, 0, 1};
    else    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
    repeat (8) step();
    for (int i = 0; i < 8; i++) check($sformatf("both_seq[%0d]", i), acklog[s+i], exp_seq[i]);
    bus.m0_req = 0; bus.m1_req = 0;

    // Locked M1 burst of 20 beats with M0 requesting from the second cycle
    bus.m1_req = 1; bus.m1_lock = 1; bus.m1_addr = 32'h0;
    s = acklog.size();
    m1_beats = 0;
    step();
    bus.m0_req = 1; bus.m0_addr = 32'h10;
    for (int i = 0; i < 30; i++) begin
      step();
      if (acklog[$] == 2) begin
        m1_beats++;
        bus.m1_addr = bus.m1_addr + 32'h4;
        if (m1_beats == 20) bus.m1_req = 0;
      end
      if (acklog[$] == 1) bus.m0_req = 0;
    end
    bus.m1_lock = 0;
    check("burst_first_idle", acklog[s], 0);
    for (int i = 1; i <= 16; i++) check($sformatf("burst_m1[%0d]", i), acklog[s+i], 2);
    check("burst_release_idle", acklog[s+17], 0);
    check("burst_then_m0", acklog[s+18], 1);
    check("burst_total_m1", m1_beats, 20);

    // Reset for two cycles in the middle of a locked burst
    step();
    bus.m1_req = 1; bus.m1_lock = 1; bus.m1_addr = 32'h0;
    step(); step(); step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("rst_mid_ce", bus.ram_ce, 1'b0);
    check("rst_mid_ack", bus.m1_ack, 1'b0);
    step();
    rst = 1'b0; bus.m1_req = 0; bus.m1_lock = 0;
    @(negedge clk);
    check("rst_after_ce", bus.ram_ce, 1'b0);
    check("rst_after_acks", {bus.m0_ack, bus.m1_ack}, 2'b00);
    check("rst_lock_cnt", dut.lock_cnt, 0);

    // M0 withdraws its request while granted
    step();
    bus.m0_req = 1; bus.m0_addr = 32'h10;
    step();
    bus.m0_req = 0;
    @(negedge clk);
    check("wd_ce", bus.ram_ce, 1'b0);
    check("wd_ack", bus.m0_ack, 1'b0);
    step();
    bus.m0_req = 1;
    @(negedge clk);
    check("wd_idle_ack", bus.m0_ack, 1'b0);
    step();
    @(negedge clk);
    check("wd_regrant_ack", bus.m0_ack, 1'b1);
    step();
    bus.m0_req = 0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
